mips_mc_control: RTL and testbench
==================================

MIPS_MC_CONTROL -- requirements
Module: mips_mc_control

Interface
REQ-001 Parameter OPCODE_W, default 6, opcode field width.
REQ-002 Parameter ALUOP_W, default 6, ALUOp width; ALUOP_W >= OPCODE_W.
REQ-003 Parameter CNT_W, default 32, retired-instruction counter width.
REQ-004 Parameter WAIT_LIMIT, default 255, maximum consecutive waitrequest cycles before fault; must be >= 1.
REQ-005 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-006 Remaining ports SHALL be:
- opcode  input  OPCODE_W  opcode from the instruction register.
- halt_req  input  1  halt request, sampled in FETCH.
- instr_waitrequest  input  1  instruction memory busy.
- data_waitrequest  input  1  data memory busy.
- instr_read  output  1  instruction fetch strobe.
- ir_write, pc_write  output  1 each  IR load; PC advance.
- RegDst, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, RegWrite  output  1 each  datapath controls.
- ALUOp  output  ALUOP_W  zero-extended latched opcode.
- state  output  3  current state.
- halted, fault  output  1 each  status.
- instr_count  output  CNT_W  retired instructions.

Function
REQ-007 States SHALL be encoded FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6; code 7 SHALL go to FAULT next cycle.
REQ-008 FETCH:
- If halt_req=1, go to HALT with no fetch that cycle.
- Otherwise assert instr_read and hold while instr_waitrequest=1.
- When instr_waitrequest=0, assert ir_write and pc_write for exactly that cycle and go to DECODE.
REQ-009 DECODE SHALL latch opcode into an internal register and classify it:
- 0 = R-type.
- 2 and 3 = jump.
- 4 and 5 = branch.
- 8..15 = I-ALU.
- 0x23 = LW.
- 0x2B = SW.
- Anything else = illegal, go to FAULT.
REQ-010 EXEC control outputs:
- R-type: RegDst=1, ALUSrc=0.
- I-ALU, LW and SW: RegDst=0, ALUSrc=1.
- Branch and jump: Branch=1, ALUSrc=0.
REQ-011 Transitions out of EXEC: branch and jump retire to FETCH; LW and SW go to MEM; R-type and I-ALU go to WB.
REQ-012 MEM SHALL assert MemRead (LW) or MemWrite (SW) and hold while data_waitrequest=1. On release: SW retires to FETCH, LW goes to WB.
REQ-013 WB SHALL assert RegWrite for one cycle, with MemtoReg=1 for LW only and RegDst as in EXEC, then retire to FETCH.
REQ-014 ALUOp SHALL equal the latched opcode in DECODE through WB and 0 otherwise.
REQ-015 All datapath controls not listed for a state SHALL be 0; outputs are combinational from state and the latched opcode.
REQ-016 Latency from FETCH entry, with zero wait cycles: branch/jump 3 cycles; R-type, I-ALU and SW 4 cycles; LW 5 cycles.
REQ-017 instr_count SHALL increment by 1 on each retire and wrap modulo 2^CNT_W.
REQ-018 Watchdog counter:
- Counts consecutive cycles with waitrequest=1 in FETCH or MEM.
- Clears on any cycle without a stall.
- When the count reaches WAIT_LIMIT while still stalled, go to FAULT on the next edge.
REQ-019 HALT and FAULT SHALL be absorbing until reset, with all strobes 0 and halted=1 or fault=1 respectively. halt_req outside FETCH SHALL be ignored.
REQ-020 If halt_req and instr_waitrequest are both 1 in FETCH, halt takes priority.

Reset
REQ-021 rst_n=0 SHALL asynchronously force state=FETCH, instr_count=0, watchdog=0, latched opcode=0, halted=0 and fault=0, so during reset instr_read=1 and every other strobe is 0.
REQ-022 Reset asserted mid-instruction SHALL abandon it without retiring. The first rising edge after release SHALL evaluate FETCH.

Verification
REQ-023 Reset, then opcode=0 with no waits -> states 0,1,2,4,0; RegWrite=1 with RegDst=1 only in cycle 4; instr_count=1.
REQ-024 opcode=0x23 with data_waitrequest high for 3 cycles -> MEM held 4 cycles, then WB with MemtoReg=1 and RegWrite=1; instr_count +1.
REQ-025 opcode=0x2B -> MemWrite=1 for one cycle, RegWrite never 1, return to FETCH after 4 cycles.
REQ-026 opcode=0x3F -> FETCH, DECODE, FAULT; fault=1 held until rst_n low; instr_count unchanged.
REQ-027 WAIT_LIMIT=4 with instr_waitrequest stuck at 1 -> FAULT after the 4th stalled cycle. Separately, halt_req=1 in FETCH -> HALT, halted=1, instr_read=0.
REQ-028 CNT_W=2, 5 back-to-back beq (opcode 4) -> instr_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/mips_mc_control.sv
// ---------------------------------------------------------------------------
// mips_mc_control
//   Multi-cycle MIPS control unit. It steps each instruction through
//   FETCH -> DECODE -> EXEC -> [MEM] -> [WB], handshaking with instruction
//   and data memories that can stall. A watchdog faults the core when a
//   memory stalls for too long. HALT and FAULT are absorbing until reset.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   opcode              opcode field from the instruction register
//   halt_req            halt request, only honoured in FETCH
//   instr_waitrequest   instruction memory busy
//   data_waitrequest    data memory busy
//   instr_read          instruction fetch strobe
//   ir_write, pc_write  IR load / PC advance (one cycle per fetch)
//   RegDst .. RegWrite  datapath controls
//   ALUOp               zero-extended opcode of the instruction in flight
//   state               current state code
//   halted, fault       status flags
//   instr_count         retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module mips_mc_control #(
    parameter int OPCODE_W   = 6,
    parameter int ALUOP_W    = 6,
    parameter int CNT_W      = 32,
    parameter int WAIT_LIMIT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                halt_req,
    input  logic                instr_waitrequest,
    input  logic                data_waitrequest,
    output logic                instr_read,
    output logic                ir_write,
    output logic                pc_write,
    output logic                RegDst,
    output logic                ALUSrc,
    output logic                Branch,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic [2:0]          state,
    output logic                halted,
    output logic                fault,
    output logic [CNT_W-1:0]    instr_count
);

    localparam int WD_W = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE,
        C_JUMP,
        C_BRANCH,
        C_IALU,
        C_LW,
        C_SW,
        C_ILLEGAL
    } iclass_t;

    function automatic iclass_t classify(input logic [OPCODE_W-1:0] op);
        int unsigned v;
        v = 32'(op);
        if (v == 0)                  return C_RTYPE;
        else if (v == 2 || v == 3)   return C_JUMP;
        else if (v == 4 || v == 5)   return C_BRANCH;
        else if (v >= 8 && v <= 15)  return C_IALU;
        else if (v == 'h23)          return C_LW;
        else if (v == 'h2B)          return C_SW;
        else                         return C_ILLEGAL;
    endfunction

    state_t                state_q, state_d;
    logic [OPCODE_W-1:0]   op_q;
    logic [WD_W-1:0]       wd_q;
    logic [CNT_W-1:0]      count_q;
    logic                  retire;
    logic                  halt_take;
    logic                  stall;
    logic                  wd_expire;
    iclass_t               dec_class;
    iclass_t               cur_class;

    // Halt is masked while reset is held so the reset-time outputs show a
    // plain fetch regardless of what halt_req is doing.
    assign halt_take = rst_n & halt_req;

    assign stall = ((state_q == S_FETCH) && !halt_take && instr_waitrequest) ||
                   ((state_q == S_MEM) && data_waitrequest);

    // This cycle is the WAIT_LIMIT-th consecutive stalled one.
    assign wd_expire = stall && (wd_q == WD_W'(WAIT_LIMIT - 1));

    assign dec_class = classify(opcode);
    assign cur_class = classify(op_q);

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Latched opcode, watchdog and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            wd_q    <= '0;
            count_q <= '0;
        end else begin
            if (state_q == S_DECODE) begin
                op_q <= opcode;
            end
            wd_q <= stall ? wd_q + WD_W'(1) : '0;
            if (retire) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                if (halt_take) begin
                    state_d = S_HALT;
                end else if (instr_waitrequest) begin
                    if (wd_expire) state_d = S_FAULT;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = (dec_class == C_ILLEGAL) ? S_FAULT : S_EXEC;
            end
            S_EXEC: begin
                unique case (cur_class)
                    C_JUMP, C_BRANCH: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                    C_LW, C_SW: state_d = S_MEM;
                    C_RTYPE, C_IALU: state_d = S_WB;
                    default: state_d = S_FAULT;
                endcase
            end
            S_MEM: begin
                if (data_waitrequest) begin
                    if (wd_expire) state_d = S_FAULT;
                end else if (cur_class == C_SW) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;   // unused code 7
        endcase
    end

    // ---------------------------------------------------------------------
    // Output logic
    // ---------------------------------------------------------------------
    always_comb begin
        instr_read = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        RegDst     = 1'b0;
        ALUSrc     = 1'b0;
        Branch     = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        ALUOp      = '0;
        halted     = 1'b0;
        fault      = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                instr_read = !halt_take;
                // Gated by rst_n so no IR/PC load is signalled during reset.
                ir_write   = rst_n && !halt_take && !instr_waitrequest;
                pc_write   = rst_n && !halt_take && !instr_waitrequest;
            end
            S_DECODE: begin
                // The opcode is being captured this cycle; present it
                // directly so ALUOp already reflects the new instruction.
                ALUOp = ALUOP_W'(opcode);
            end
            S_EXEC: begin
                ALUOp = ALUOP_W'(op_q);
                unique case (cur_class)
                    C_RTYPE:               RegDst = 1'b1;
                    C_IALU, C_LW, C_SW:    ALUSrc = 1'b1;
                    C_JUMP, C_BRANCH:      Branch = 1'b1;
                    default: ;
                endcase
            end
            S_MEM: begin
                ALUOp    = ALUOP_W'(op_q);
                MemRead  = (cur_class == C_LW);
                MemWrite = (cur_class == C_SW);
            end
            S_WB: begin
                ALUOp    = ALUOP_W'(op_q);
                RegWrite = 1'b1;
                MemtoReg = (cur_class == C_LW);
                RegDst   = (cur_class == C_RTYPE);
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: ;
        endcase
    end

    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// ---------------------------------------------------------------------------
// tb_mips_mc_control
//   Randomized bench for mips_mc_control. A stimulus process walks whole
//   instructions, and for every cycle pushes the outputs the instruction's
//   phase sequence implies (fetch stalls, decode, exec, memory stalls,
//   write-back) into a scoreboard. A monitor samples the DUT on each falling
//   edge and compares against the head of the scoreboard.
// ---------------------------------------------------------------------------
module tb_mips_mc_control;

    localparam int CNT_W      = 2;
    localparam int WAIT_LIMIT = 4;

    localparam int K_R   = 0;
    localparam int K_J   = 1;
    localparam int K_BR  = 2;
    localparam int K_I   = 3;
    localparam int K_LW  = 4;
    localparam int K_SW  = 5;
    localparam int K_ILL = 6;

    typedef struct packed {
        logic [2:0] st;
        logic       ird;
        logic       irw;
        logic       pcw;
        logic       rd;
        logic       as;
        logic       br;
        logic       mr;
        logic       mw;
        logic       m2r;
        logic       rw;
        logic [5:0] aluop;
        logic       hlt;
        logic       flt;
        logic [1:0] cnt;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic       halt_req = 1'b0;
    logic       instr_waitrequest = 1'b0;
    logic       data_waitrequest = 1'b0;
    logic       instr_read, ir_write, pc_write;
    logic       RegDst, ALUSrc, Branch, MemRead, MemWrite, MemtoReg, RegWrite;
    logic [5:0] ALUOp;
    logic [2:0] state;
    logic       halted, fault;
    logic [CNT_W-1:0] instr_count;

    always #5 clk = ~clk;

    mips_mc_control #(
        .OPCODE_W  (6),
        .ALUOP_W   (6),
        .CNT_W     (CNT_W),
        .WAIT_LIMIT(WAIT_LIMIT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .opcode           (opcode),
        .halt_req         (halt_req),
        .instr_waitrequest(instr_waitrequest),
        .data_waitrequest (data_waitrequest),
        .instr_read       (instr_read),
        .ir_write         (ir_write),
        .pc_write         (pc_write),
        .RegDst           (RegDst),
        .ALUSrc           (ALUSrc),
        .Branch           (Branch),
        .MemRead          (MemRead),
        .MemWrite         (MemWrite),
        .MemtoReg         (MemtoReg),
        .RegWrite         (RegWrite),
        .ALUOp            (ALUOp),
        .state            (state),
        .halted           (halted),
        .fault            (fault),
        .instr_count      (instr_count)
    );

    obs_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   exp_cnt     = 0;   // model of retired instructions, mod 2^CNT_W

    logic [5:0] legal_ops [15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                                   6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                                   6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};

    // ---------------------------------------------------------------- model
    function automatic int cls_of(input logic [5:0] op);
        if (op == 6'h00)                 return K_R;
        if (op == 6'h02 || op == 6'h03)  return K_J;
        if (op == 6'h04 || op == 6'h05)  return K_BR;
        if (op >= 6'h08 && op <= 6'h0F)  return K_I;
        if (op == 6'h23)                 return K_LW;
        if (op == 6'h2B)                 return K_SW;
        return K_ILL;
    endfunction

    function automatic obs_t mk(input logic [2:0] st, input logic [5:0] aluop);
        obs_t e;
        e       = '0;
        e.st    = st;
        e.aluop = aluop;
        e.hlt   = (st == 3'd5);
        e.flt   = (st == 3'd6);
        e.cnt   = CNT_W'(exp_cnt);
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [5:0] rop();
        return 6'($urandom);
    endfunction

    function automatic logic [5:0] pick_op();
        if ($urandom_range(9) < 8) return legal_ops[$urandom_range(14)];
        return rop();
    endfunction

    task automatic retire_one();
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    endtask

    // ------------------------------------------------------------ stimulus
    task automatic step(input logic iw, input logic dw, input logic hr,
                        input logic [5:0] op, input obs_t e);
        @(posedge clk);
        #1;
        rst_n             = 1'b1;
        instr_waitrequest = iw;
        data_waitrequest  = dw;
        halt_req          = hr;
        opcode            = op;
        sb.push_back(e);
    endtask

    // Reset is asserted 1 time unit after an edge, i.e. mid-cycle.
    task automatic do_reset();
        obs_t e;
        @(posedge clk);
        #1;
        rst_n             = 1'b0;
        instr_waitrequest = 1'b0;
        data_waitrequest  = rb();
        halt_req          = rb();
        opcode            = rop();
        exp_cnt           = 0;
        e                 = mk(3'd0, 6'h00);
        e.ird             = 1'b1;
        sb.push_back(e);
    endtask

    task automatic fault_cycles(input int n);
        for (int i = 0; i < n; i++) step(rb(), rb(), rb(), rop(), mk(3'd6, 6'h00));
    endtask

    task automatic halt_seq();
        step(rb(), rb(), 1'b1, rop(), mk(3'd0, 6'h00));
        for (int i = 0; i < 3; i++) step(rb(), rb(), rb(), rop(), mk(3'd5, 6'h00));
    endtask

    // One instruction: nfw fetch stalls, ndw memory stalls. A stall run of
    // WAIT_LIMIT cycles ends in FAULT instead of progressing.
    task automatic run_instr(input logic [5:0] op, input int nfw, input int ndw,
                             output logic faulted);
        obs_t e;
        int   c;
        faulted = 1'b0;
        c = cls_of(op);
        for (int i = 0; i < nfw && i < WAIT_LIMIT; i++) begin
            e = mk(3'd0, 6'h00); e.ird = 1'b1;
            step(1'b1, rb(), 1'b0, rop(), e);
        end
        if (nfw >= WAIT_LIMIT) begin
            fault_cycles(3); faulted = 1'b1; return;
        end
        e = mk(3'd0, 6'h00); e.ird = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        step(1'b0, rb(), 1'b0, rop(), e);
        step(rb(), rb(), rb(), op, mk(3'd1, op));
        if (c == K_ILL) begin
            fault_cycles(3); faulted = 1'b1; return;
        end
        e = mk(3'd2, op);
        e.rd = (c == K_R);
        e.as = (c == K_I || c == K_LW || c == K_SW);
        e.br = (c == K_J || c == K_BR);
        step(rb(), rb(), rb(), rop(), e);
        if (c == K_J || c == K_BR) begin
            retire_one(); return;
        end
        if (c == K_LW || c == K_SW) begin
            for (int i = 0; i <= ndw && i < WAIT_LIMIT; i++) begin
                e = mk(3'd3, op); e.mr = (c == K_LW); e.mw = (c == K_SW);
                step(rb(), (i < ndw), rb(), rop(), e);
            end
            if (ndw >= WAIT_LIMIT) begin
                fault_cycles(3); faulted = 1'b1; return;
            end
            if (c == K_SW) begin
                retire_one(); return;
            end
        end
        e = mk(3'd4, op); e.rw = 1'b1; e.m2r = (c == K_LW); e.rd = (c == K_R);
        step(rb(), rb(), rb(), rop(), e);
        retire_one();
    endtask

    // ------------------------------------------------------------- monitor
    initial begin : monitor
        obs_t got, want;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                want = sb.pop_front();
                got  = '{st: state, ird: instr_read, irw: ir_write, pcw: pc_write,
                         rd: RegDst, as: ALUSrc, br: Branch, mr: MemRead,
                         mw: MemWrite, m2r: MemtoReg, rw: RegWrite, aluop: ALUOp,
                         hlt: halted, flt: fault, cnt: instr_count};
                vectors++;
                if (got !== want) begin
                    miscompares++;
                    $display("FAIL cycle@%0t: got st=%0d ctl=%b aluop=%h cnt=%0d, want st=%0d ctl=%b aluop=%h cnt=%0d",
                             $time, got.st, got[19:10], got.aluop, got.cnt,
                             want.st, want[19:10], want.aluop, want.cnt);
                end
            end
        end
    end

    // ---------------------------------------------------------- main flow
    initial begin : stimulus
        logic f;
        logic [5:0] op;
        int r;

        do_reset();
        run_instr(6'h00, 0, 0, f);               // R-type, no waits
        run_instr(6'h23, 0, 3, f);               // LW, 3 data stalls
        run_instr(6'h2B, 0, 0, f);               // SW
        run_instr(6'h3F, 0, 0, f);               // illegal -> FAULT
        do_reset();
        halt_seq();
        do_reset();
        run_instr(6'h00, WAIT_LIMIT, 0, f);      // fetch watchdog
        do_reset();
        run_instr(6'h23, 1, WAIT_LIMIT, f);      // memory watchdog
        do_reset();
        for (int i = 0; i < 5; i++) run_instr(6'h04, 0, 0, f);  // count wraps

        // Abandon an LW in MEM; nothing retires, next instruction counts 1.
        run_instr(6'h00, 0, 0, f);
        do_reset();
        begin
            obs_t e;
            e = mk(3'd0, 6'h00); e.ird = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
            step(1'b0, 1'b0, 1'b0, rop(), e);
            step(1'b0, 1'b0, 1'b0, 6'h23, mk(3'd1, 6'h23));
            e = mk(3'd2, 6'h23); e.as = 1'b1;
            step(1'b0, 1'b1, 1'b0, rop(), e);
            e = mk(3'd3, 6'h23); e.mr = 1'b1;
            step(1'b0, 1'b1, 1'b0, rop(), e);
        end
        do_reset();
        run_instr(6'h08, 0, 0, f);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(99);
            if (r < 4) begin
                do_reset();
            end else if (r < 7) begin
                halt_seq();
                do_reset();
            end else if (r < 10) begin
                op = pick_op();
                if (r[0]) run_instr(op, WAIT_LIMIT, 0, f);
                else      run_instr(op, 0, WAIT_LIMIT, f);
                do_reset();
            end else begin
                run_instr(pick_op(), $urandom_range(WAIT_LIMIT - 1),
                          $urandom_range(WAIT_LIMIT - 1), f);
                if (f) do_reset();
            end
        end

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
